// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch PC sequencer: data width, instruction lengths, FSM states.
package pc_seq_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ILEN16 = 2;
    localparam int unsigned ILEN32 = 4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH,
        S_TRAP
    } pc_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational address arithmetic for the sequencer: sequential next PC and redirect target.
module pc_next_calc
    import pc_seq_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            is_compressed_i,
    input  logic            br_is_jalr_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic [XLEN-1:0] pc_seq_o,
    output logic [XLEN-1:0] target_o,
    output logic            target_misaligned_o
);

    // Wraps modulo 2^XLEN naturally.
    assign pc_seq_o = pc_i + (is_compressed_i ? XLEN'(ILEN16) : XLEN'(ILEN32));

    // JALR clears bit 0 of its target, so it can never be misaligned on a 16-bit boundary.
    assign target_o            = br_is_jalr_i ? {br_target_i[XLEN-1:1], 1'b0} : br_target_i;
    assign target_misaligned_o = ~br_is_jalr_i & br_target_i[0];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequential advance, taken-branch redirect with fetch flush, misaligned-target trap.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        instr_valid_i,
    input  logic        is_compressed_i,
    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic        br_is_jalr_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus_o,
    output logic        fetch_req_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic [31:0] misalign_addr_o
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

    // Bit 0 forced low so pc_o stays halfword aligned even with an odd RESET_PC.
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:1], 1'b0};

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             fetch_req_q, fetch_req_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [XLEN-1:0]  pc_seq;
    logic [XLEN-1:0]  eff_target;
    logic             target_misaligned;
    logic             redirect;

    pc_next_calc u_next_calc (
        .pc_i                (pc_q),
        .is_compressed_i     (is_compressed_i),
        .br_is_jalr_i        (br_is_jalr_i),
        .br_target_i         (br_target_i),
        .pc_seq_o            (pc_seq),
        .target_o            (eff_target),
        .target_misaligned_o (target_misaligned)
    );

    assign redirect = br_valid_i & br_taken_i;

    // Next-state and next-output selection; redirect outranks stall and instr_valid in S_RUN.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        fetch_req_d     = fetch_req_q;
        flush_d         = 1'b0;
        misalign_d      = misalign_q;
        misalign_addr_d = misalign_addr_q;
        flush_cnt_d     = flush_cnt_q;

        case (state_q)
            S_BOOT: begin
                state_d     = S_RUN;
                fetch_req_d = 1'b1;
            end
            S_RUN: begin
                if (redirect) begin
                    fetch_req_d = 1'b0;
                    if (target_misaligned) begin
                        state_d         = S_TRAP;
                        misalign_d      = 1'b1;
                        misalign_addr_d = br_target_i;
                    end else begin
                        state_d     = S_FLUSH;
                        pc_d        = eff_target;
                        flush_d     = 1'b1;
                        flush_cnt_d = CNT_W'(FLUSH_CYCLES);
                    end
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (instr_valid_i) begin
                    pc_d = pc_seq;
                end
            end
            S_FLUSH: begin
                // Wrong-path returns and branches are dropped until the counter runs out.
                if (flush_cnt_q <= CNT_W'(1)) begin
                    flush_cnt_d = '0;
                    fetch_req_d = 1'b1;
                    state_d     = S_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            S_TRAP: begin
                fetch_req_d = 1'b0;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_BOOT;
            pc_q            <= RESET_PC_ALIGNED;
            fetch_req_q     <= 1'b0;
            flush_q         <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            fetch_req_q     <= fetch_req_d;
            flush_q         <= flush_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_plus_o       = pc_seq;
    assign fetch_req_o     = fetch_req_q;
    assign flush_o         = flush_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, a flush-latency sequence, then random stimulus
// checked against a cycle-stamped behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned FC       = 2;
    localparam int          M_BOOT   = 0;
    localparam int          M_RUN    = 1;
    localparam int          M_FLUSH  = 2;
    localparam int          M_TRAP   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, instr_valid_i, is_compressed_i;
    logic        br_valid_i, br_taken_i, br_is_jalr_i;
    logic [31:0] br_target_i;
    logic [31:0] pc_o, pc_plus_o, misalign_addr_o;
    logic        fetch_req_o, flush_o, misalign_o;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .instr_valid_i   (instr_valid_i),
        .is_compressed_i (is_compressed_i),
        .br_valid_i      (br_valid_i),
        .br_taken_i      (br_taken_i),
        .br_is_jalr_i    (br_is_jalr_i),
        .br_target_i     (br_target_i),
        .pc_o            (pc_o),
        .pc_plus_o       (pc_plus_o),
        .fetch_req_o     (fetch_req_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o)
    );

    typedef struct {
        logic        rst, stall, iv, comp, bv, bt, bj;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_req, e_flush, e_mis;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state: outputs expected after the next edge.
    int          m_mode;
    logic [31:0] m_pc, m_addr;
    logic        m_req, m_flush, m_mis;
    int          cyc;
    int          m_resume;

    function automatic vec_t v(input logic r, s, iv, c, bv, bt, bj, input logic [31:0] tgt,
                               input logic [31:0] epc, input logic req, fl, mis,
                               input logic [31:0] addr);
        vec_t x;
        x.rst = r; x.stall = s; x.iv = iv; x.comp = c; x.bv = bv; x.bt = bt; x.bj = bj;
        x.tgt = tgt; x.e_pc = epc; x.e_req = req; x.e_flush = fl; x.e_mis = mis; x.e_addr = addr;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; stall_i = x.stall; instr_valid_i = x.iv; is_compressed_i = x.comp;
        br_valid_i = x.bv; br_taken_i = x.bt; br_is_jalr_i = x.bj; br_target_i = x.tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each redirect stamps the cycle at which fetching resumes.
    task automatic model_edge();
        if (rst) begin
            m_mode = M_BOOT; m_pc = RESET_PC; m_req = 0; m_flush = 0; m_mis = 0; m_addr = 0;
        end else begin
            m_flush = 0;
            if (m_mode == M_BOOT) begin
                m_mode = M_RUN;
                m_req  = 1;
            end else if (m_mode == M_RUN) begin
                if (br_valid_i && br_taken_i) begin
                    m_req = 0;
                    if (!br_is_jalr_i && br_target_i[0]) begin
                        m_mode = M_TRAP; m_mis = 1; m_addr = br_target_i;
                    end else begin
                        m_pc     = br_is_jalr_i ? (br_target_i & 32'hFFFF_FFFE) : br_target_i;
                        m_flush  = 1;
                        m_resume = cyc + 1 + FC;
                        m_mode   = M_FLUSH;
                    end
                end else if (!stall_i && instr_valid_i) begin
                    m_pc = m_pc + (is_compressed_i ? 32'd2 : 32'd4);
                end
            end else if (m_mode == M_FLUSH) begin
                if (cyc + 1 == m_resume) begin
                    m_req  = 1;
                    m_mode = M_RUN;
                end
            end
        end
    endtask

    initial begin
        int n;
        vec_t x;

        rst = 1; stall_i = 0; instr_valid_i = 0; is_compressed_i = 0;
        br_valid_i = 0; br_taken_i = 0; br_is_jalr_i = 0; br_target_i = 0;

        // rst  st iv  c bv bt bj target         pc            req fl mis addr
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h4,        1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 32'h0,        32'h6,        1, 0, 0, 32'h0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h0,        32'h6,        1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 32'h0,        32'h8,        1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 32'h0,        32'hC,        1, 0, 0, 32'h0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1, 0, 32'h40,       32'h40,       0, 1, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 0, 1, 1, 0, 32'h100,      32'h40,       0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h40,       1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h44,       1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 1, 32'h81,       32'h80,       0, 1, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h80,       0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h80,       1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 32'h81,       32'h80,       0, 0, 1, 32'h81));
        vecs.push_back(v(0, 1, 1, 1, 1, 1, 1, 32'h200,      32'h80,       0, 0, 1, 32'h81));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 1, 32'hFFFFFFFD, 32'hFFFFFFFC, 0, 1, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFC, 0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFC, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 0, 1, 0, 0, 32'h1234,     32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 32'h10,       32'h10,       0, 1, 0, 32'h0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFE, 0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFE, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0));

        foreach (vecs[i]) begin
            x = vecs[i];
            drive(x);
            step();
            chk($sformatf("vec%0d pc_o", i), pc_o, x.e_pc);
            chk($sformatf("vec%0d pc_plus_o", i), pc_plus_o,
                x.e_pc + (x.comp ? 32'd2 : 32'd4));
            chk($sformatf("vec%0d fetch_req_o", i), {31'b0, fetch_req_o}, {31'b0, x.e_req});
            chk($sformatf("vec%0d flush_o", i), {31'b0, flush_o}, {31'b0, x.e_flush});
            chk($sformatf("vec%0d misalign_o", i), {31'b0, misalign_o}, {31'b0, x.e_mis});
            chk($sformatf("vec%0d misalign_addr_o", i), misalign_addr_o, x.e_addr);
        end

        // Redirect, then hammer the flush window with stall/valid/branch; count dark cycles.
        drive(v(0, 0, 0, 0, 1, 1, 0, 32'h300, 0, 0, 0, 0, 0));
        step();
        drive(v(0, 1, 1, 0, 1, 1, 0, 32'h500, 0, 0, 0, 0, 0));
        n = 0;
        while (!fetch_req_o && n < 10) begin
            n++;
            step();
            chk("flush_window flush_o", {31'b0, flush_o}, 32'h0);
        end
        chk("flush_window dark_cycles", n, FC);
        chk("flush_window pc_o", pc_o, 32'h300);
        drive(v(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));

        // Random stimulus against the model; first cycle always resets.
        cyc = 0;
        m_resume = 0;
        for (int k = 0; k < 3000; k++) begin
            rst             = (k == 0) || ($urandom_range(63) == 0);
            stall_i         = ($urandom_range(3) == 0);
            instr_valid_i   = $urandom_range(1) == 1;
            is_compressed_i = $urandom_range(1) == 1;
            br_valid_i      = ($urandom_range(5) == 0);
            br_taken_i      = $urandom_range(1) == 1;
            br_is_jalr_i    = ($urandom_range(2) == 0);
            br_target_i     = $urandom;
            if ($urandom_range(7) == 0) br_target_i = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            model_edge();
            step();
            cyc++;
            chk("rand pc_o", pc_o, m_pc);
            chk("rand pc_plus_o", pc_plus_o, m_pc + (is_compressed_i ? 32'd2 : 32'd4));
            chk("rand fetch_req_o", {31'b0, fetch_req_o}, {31'b0, m_req});
            chk("rand flush_o", {31'b0, flush_o}, {31'b0, m_flush});
            chk("rand misalign_o", {31'b0, misalign_o}, {31'b0, m_mis});
            chk("rand misalign_addr_o", misalign_addr_o, m_addr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
